sata_transport_pio_rx: RTL and testbench

SATA_TRANSPORT_PIO_RX -- requirements
Module: sata_transport_pio_rx

---
 rtl/sata_transport_pkg.sv | 43 ++++
 rtl/sata_transport_pio_rx.sv | 218 +++++++++++++++++++++
 tb/tb_sata_transport_pio_rx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sata_transport_pkg.sv
// ---------------------------------------------------------------------------
// sata_transport_pkg
// Shared definitions for the SATA transport-layer PIO receive path:
//   - FIS type codes for PIO Setup and Data FIS
//   - bit positions inside the link tuser sideband
//   - receive FSM state encoding
//   - PIO Setup descriptor record
//   - popcount4 helper used to turn a byte-keep mask into a byte count
// ---------------------------------------------------------------------------
package sata_transport_pkg;

    localparam logic [7:0] FIS_TYPE_PIO_SETUP = 8'h5F;
    localparam logic [7:0] FIS_TYPE_DATA      = 8'h46;

    // tuser layout: {drop, err, keep[3:0], sop, eop}
    localparam int TU_EOP     = 0;
    localparam int TU_SOP     = 1;
    localparam int TU_KEEP_LO = 2;
    localparam int TU_KEEP_HI = 5;
    localparam int TU_ERR     = 6;
    localparam int TU_DROP    = 7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PIO_HDR = 2'd1,
        ST_DATA    = 2'd2,
        ST_SKIP    = 2'd3
    } pio_rx_state_e;

    typedef struct packed {
        logic        dir;
        logic        irq;
        logic [7:0]  status;
        logic [7:0]  error;
        logic [7:0]  estatus;
        logic [15:0] xfer_cnt;
    } pio_desc_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/sata_transport_pio_rx.sv
// ---------------------------------------------------------------------------
// sata_transport_pio_rx
// Receives FISes from the link layer, decodes PIO Setup FISes into a
// descriptor and tracks the number of bytes still outstanding in the PIO
// data phase as Data FIS payload streams past.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_aixs_link_tdata[31:0]  link dword, FIS byte 0 in [31:24]
//   s_aixs_link_tuser        {drop, err, keep[3:0], sop, eop}
//   s_aixs_link_tvalid       beat valid
//   s_aixs_link_tready       beat accept (combinational)
//   pio_setup                pulse: PIO Setup FIS captured
//   pio_valid / pio_ready    descriptor handshake
//   pio_dir, pio_irq         D and I flags of the PIO Setup FIS
//   pio_status, pio_error    status / error bytes
//   pio_estatus              ending status byte
//   pio_xfer_cnt             transfer count in bytes
//   pio_remain               bytes still outstanding in the data phase
//   pio_done                 pulse: pio_remain reached zero via payload
//   fis_err                  pulse: malformed, errored or overrunning FIS
// ---------------------------------------------------------------------------
module sata_transport_pio_rx
    import sata_transport_pkg::*;
#(
    parameter int         USER_W    = 8,
    parameter logic [7:0] PIO_TYPE  = FIS_TYPE_PIO_SETUP,
    parameter logic [7:0] DATA_TYPE = FIS_TYPE_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       s_aixs_link_tdata,
    input  logic [USER_W-1:0] s_aixs_link_tuser,
    input  logic              s_aixs_link_tvalid,
    output logic              s_aixs_link_tready,
    output logic              pio_setup,
    output logic              pio_valid,
    input  logic              pio_ready,
    output logic              pio_dir,
    output logic              pio_irq,
    output logic [7:0]        pio_status,
    output logic [7:0]        pio_error,
    output logic [7:0]        pio_estatus,
    output logic [15:0]       pio_xfer_cnt,
    output logic [15:0]       pio_remain,
    output logic              pio_done,
    output logic              fis_err
);

    // Subtract a beat's byte count from the outstanding count. Bit 16 of the
    // result flags an overrun; the count then clamps at zero.
    function automatic logic [16:0] sub_remain(input logic [15:0] rem,
                                               input logic [2:0]  n);
        logic [15:0] n_ext;
        n_ext = {13'd0, n};
        if (n_ext > rem)
            return {1'b1, 16'd0};
        else
            return {1'b0, rem - n_ext};
    endfunction

    pio_rx_state_e state;
    logic [2:0]    idx;
    logic          hdr_dir;
    logic          hdr_irq;
    logic [7:0]    hdr_status;
    logic [7:0]    hdr_error;
    logic [7:0]    hdr_estatus;
    pio_desc_t     desc;
    logic [15:0]   remain;
    logic          valid_r;
    logic          setup_r;
    logic          done_r;
    logic          ferr_r;
    logic          ovr;       // payload overran this Data FIS; ignore the rest

    logic          beat;
    logic          sop;
    logic          eop;
    logic          bad;
    logic [7:0]    fis_type;
    logic [2:0]    keep_n;
    logic [16:0]   sub_res;
    logic [15:0]   xfer_in;

    assign sop      = s_aixs_link_tuser[TU_SOP];
    assign eop      = s_aixs_link_tuser[TU_EOP];
    assign bad      = s_aixs_link_tuser[TU_ERR] | s_aixs_link_tuser[TU_DROP];
    assign fis_type = s_aixs_link_tdata[31:24];
    assign keep_n   = popcount4(s_aixs_link_tuser[TU_KEEP_HI:TU_KEEP_LO]);
    assign sub_res  = sub_remain(remain, keep_n);
    // FIS bytes 17:16 hold the little-endian transfer count
    assign xfer_in  = {s_aixs_link_tdata[23:16], s_aixs_link_tdata[31:24]};

    // Stall only the final header dword while an unconsumed descriptor would
    // otherwise be overwritten.
    assign s_aixs_link_tready = !((state == ST_PIO_HDR) && (idx == 3'd4) &&
                                  valid_r && !pio_ready);
    assign beat = s_aixs_link_tvalid && s_aixs_link_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            hdr_dir     <= 1'b0;
            hdr_irq     <= 1'b0;
            hdr_status  <= '0;
            hdr_error   <= '0;
            hdr_estatus <= '0;
            desc        <= '0;
            remain      <= '0;
            valid_r     <= 1'b0;
            setup_r     <= 1'b0;
            done_r      <= 1'b0;
            ferr_r      <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            setup_r <= 1'b0;
            done_r  <= 1'b0;
            ferr_r  <= 1'b0;
            if (valid_r && pio_ready)
                valid_r <= 1'b0;

            if (beat) begin
                // A new FIS may start from IDLE or interrupt a FIS being skipped
                if (sop && (state == ST_IDLE || state == ST_SKIP)) begin
                    if (fis_type == PIO_TYPE) begin
                        if (bad) begin
                            ferr_r <= 1'b1;
                            state  <= eop ? ST_IDLE : ST_SKIP;
                        end else if (eop) begin
                            ferr_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            state      <= ST_PIO_HDR;
                            idx        <= 3'd1;
                            hdr_dir    <= s_aixs_link_tdata[21];
                            hdr_irq    <= s_aixs_link_tdata[22];
                            hdr_status <= s_aixs_link_tdata[15:8];
                            hdr_error  <= s_aixs_link_tdata[7:0];
                        end
                    end else if (fis_type == DATA_TYPE && remain != 16'd0 && !eop) begin
                        state <= ST_DATA;
                        ovr   <= 1'b0;
                    end else begin
                        state <= eop ? ST_IDLE : ST_SKIP;
                    end
                end else begin
                    case (state)
                        ST_IDLE: ;
                        ST_SKIP: begin
                            if (eop)
                                state <= ST_IDLE;
                        end
                        ST_PIO_HDR: begin
                            if (bad) begin
                                ferr_r <= 1'b1;
                                state  <= eop ? ST_IDLE : ST_SKIP;
                            end else if (eop) begin
                                state <= ST_IDLE;
                                if (idx == 3'd4) begin
                                    desc.dir      <= hdr_dir;
                                    desc.irq      <= hdr_irq;
                                    desc.status   <= hdr_status;
                                    desc.error    <= hdr_error;
                                    desc.estatus  <= hdr_estatus;
                                    desc.xfer_cnt <= xfer_in;
                                    remain        <= xfer_in;
                                    valid_r       <= 1'b1;
                                    setup_r       <= 1'b1;
                                end else begin
                                    ferr_r <= 1'b1;
                                end
                            end else if (idx == 3'd4) begin
                                ferr_r <= 1'b1;
                                state  <= ST_SKIP;
                            end else begin
                                if (idx == 3'd3)
                                    hdr_estatus <= s_aixs_link_tdata[7:0];
                                idx <= idx + 3'd1;
                            end
                        end
                        ST_DATA: begin
                            if (bad) begin
                                ferr_r <= 1'b1;
                            end else if (!ovr && keep_n != 3'd0) begin
                                remain <= sub_res[15:0];
                                if (sub_res[16]) begin
                                    ovr    <= 1'b1;
                                    done_r <= 1'b1;
                                    ferr_r <= 1'b1;
                                end else if (sub_res[15:0] == 16'd0) begin
                                    done_r <= 1'b1;
                                end
                            end
                            if (eop)
                                state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign pio_setup    = setup_r;
    assign pio_valid    = valid_r;
    assign pio_dir      = desc.dir;
    assign pio_irq      = desc.irq;
    assign pio_status   = desc.status;
    assign pio_error    = desc.error;
    assign pio_estatus  = desc.estatus;
    assign pio_xfer_cnt = desc.xfer_cnt;
    assign pio_remain   = remain;
    assign pio_done     = done_r;
    assign fis_err      = ferr_r;

endmodule

// File: tb/tb_sata_transport_pio_rx.sv
module tb_sata_transport_pio_rx;

    logic        clk;
    logic        rst;
    logic [31:0] tdata;
    logic [7:0]  tuser;
    logic        tvalid;
    logic        tready;
    logic        pio_setup;
    logic        pio_valid;
    logic        pio_ready;
    logic        pio_dir;
    logic        pio_irq;
    logic [7:0]  pio_status;
    logic [7:0]  pio_error;
    logic [7:0]  pio_estatus;
    logic [15:0] pio_xfer_cnt;
    logic [15:0] pio_remain;
    logic        pio_done;
    logic        fis_err;

    int checks   = 0;
    int failures = 0;

    // tuser encodings {drop, err, keep[3:0], sop, eop}
    localparam logic [7:0] U_SOP   = 8'h3E;
    localparam logic [7:0] U_MID   = 8'h3C;
    localparam logic [7:0] U_EOP   = 8'h3D;
    localparam logic [7:0] U_K3EOP = 8'h0D;
    localparam logic [7:0] U_ERR   = 8'h7C;
    localparam logic [7:0] U_DROP  = 8'hBC;

    sata_transport_pio_rx #(
        .USER_W   (8),
        .PIO_TYPE (8'h5F),
        .DATA_TYPE(8'h46)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_aixs_link_tdata (tdata),
        .s_aixs_link_tuser (tuser),
        .s_aixs_link_tvalid(tvalid),
        .s_aixs_link_tready(tready),
        .pio_setup         (pio_setup),
        .pio_valid         (pio_valid),
        .pio_ready         (pio_ready),
        .pio_dir           (pio_dir),
        .pio_irq           (pio_irq),
        .pio_status        (pio_status),
        .pio_error         (pio_error),
        .pio_estatus       (pio_estatus),
        .pio_xfer_cnt      (pio_xfer_cnt),
        .pio_remain        (pio_remain),
        .pio_done          (pio_done),
        .fis_err           (fis_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one beat from a negedge and return just after the edge that
    // accepted it.
    task automatic send_beat(input logic [31:0] d, input logic [7:0] u);
        int n;
        n = 0;
        @(negedge clk);
        tdata  = d;
        tuser  = u;
        tvalid = 1'b1;
        while (!tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!tready)
            chk("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    // Drop tvalid at the next negedge: the cycle following the last beat.
    task automatic end_burst();
        @(negedge clk);
        tvalid = 1'b0;
        tuser  = 8'h00;
        tdata  = 32'h0;
    endtask

    initial begin
        rst       = 1'b1;
        tvalid    = 1'b0;
        tdata     = 32'h0;
        tuser     = 8'h00;
        pio_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_tready", {31'd0, tready}, 32'd1);
        chk("rst_valid",  {31'd0, pio_valid}, 32'd0);
        chk("rst_setup",  {31'd0, pio_setup}, 32'd0);
        chk("rst_remain", {16'd0, pio_remain}, 32'd0);
        chk("rst_xfer",   {16'd0, pio_xfer_cnt}, 32'd0);
        chk("rst_ferr",   {31'd0, fis_err}, 32'd0);

        // Well-formed PIO Setup, descriptor held (pio_ready low)
        send_beat(32'h5F24_5000, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0011, U_MID);
        send_beat(32'h0002_0000, U_EOP);
        end_burst();
        chk("p1_setup",   {31'd0, pio_setup}, 32'd1);
        chk("p1_valid",   {31'd0, pio_valid}, 32'd1);
        chk("p1_dir",     {31'd0, pio_dir}, 32'd1);
        chk("p1_irq",     {31'd0, pio_irq}, 32'd0);
        chk("p1_status",  {24'd0, pio_status}, 32'h50);
        chk("p1_error",   {24'd0, pio_error}, 32'h00);
        chk("p1_estatus", {24'd0, pio_estatus}, 32'h11);
        chk("p1_xfer",    {16'd0, pio_xfer_cnt}, 32'h0200);
        chk("p1_remain",  {16'd0, pio_remain}, 32'h0200);
        @(negedge clk);
        chk("p1_setup_pulse", {31'd0, pio_setup}, 32'd0);
        chk("p1_valid_hold",  {31'd0, pio_valid}, 32'd1);

        // Second PIO Setup stalls on its last dword until pio_ready
        send_beat(32'h5F40_7001, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0022, U_MID);
        @(negedge clk);
        tdata  = 32'h0600_0000;
        tuser  = U_EOP;
        tvalid = 1'b1;
        chk("p2_stall0", {31'd0, tready}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("p2_stall", {31'd0, tready}, 32'd0);
        end
        chk("p2_keep_status", {24'd0, pio_status}, 32'h50);
        chk("p2_keep_xfer",   {16'd0, pio_xfer_cnt}, 32'h0200);
        chk("p2_keep_est",    {24'd0, pio_estatus}, 32'h11);
        chk("p2_no_setup",    {31'd0, pio_setup}, 32'd0);
        pio_ready = 1'b1;
        @(posedge clk);
        end_burst();
        chk("p2_setup",   {31'd0, pio_setup}, 32'd1);
        chk("p2_valid",   {31'd0, pio_valid}, 32'd1);
        chk("p2_dir",     {31'd0, pio_dir}, 32'd0);
        chk("p2_irq",     {31'd0, pio_irq}, 32'd1);
        chk("p2_status",  {24'd0, pio_status}, 32'h70);
        chk("p2_error",   {24'd0, pio_error}, 32'h01);
        chk("p2_estatus", {24'd0, pio_estatus}, 32'h22);
        chk("p2_xfer",    {16'd0, pio_xfer_cnt}, 32'h0006);
        chk("p2_remain",  {16'd0, pio_remain}, 32'h0006);
        @(negedge clk);
        chk("p2_valid_clr", {31'd0, pio_valid}, 32'd0);

        // Data FIS: 6 -> 2 -> 0 with a single pio_done
        send_beat(32'h4600_0000, U_SOP);
        send_beat(32'hA1A2_A3A4, U_MID);
        #1 chk("d1_remain2", {16'd0, pio_remain}, 32'd2);
        chk("d1_no_done", {31'd0, pio_done}, 32'd0);
        send_beat(32'hB1B2_0000, U_K3EOP);
        end_burst();
        chk("d1_remain0", {16'd0, pio_remain}, 32'd0);
        chk("d1_done",    {31'd0, pio_done}, 32'd1);
        chk("d1_no_err",  {31'd0, fis_err}, 32'd0);
        @(negedge clk);
        chk("d1_done_pulse", {31'd0, pio_done}, 32'd0);

        // PIO FIS ending early on beat 2
        send_beat(32'h5F20_5000, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_EOP);
        end_burst();
        chk("e1_ferr",     {31'd0, fis_err}, 32'd1);
        chk("e1_no_setup", {31'd0, pio_setup}, 32'd0);
        chk("e1_status",   {24'd0, pio_status}, 32'h70);
        @(negedge clk);
        chk("e1_ferr_pulse", {31'd0, fis_err}, 32'd0);

        // Six-beat PIO FIS: error on dword 4, rest skipped to eop
        send_beat(32'h5F20_5000, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0004_0000, U_MID);
        #1 chk("e2_ferr", {31'd0, fis_err}, 32'd1);
        send_beat(32'h0000_0000, U_EOP);
        end_burst();
        chk("e2_ferr_once", {31'd0, fis_err}, 32'd0);
        chk("e2_no_setup",  {31'd0, pio_setup}, 32'd0);
        chk("e2_xfer",      {16'd0, pio_xfer_cnt}, 32'h0006);

        // xfer_cnt=4, payload keep=F then keep=F -> exact zero, then overrun
        send_beat(32'h5F20_5000, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0400_0000, U_EOP);
        end_burst();
        chk("o_setup",  {31'd0, pio_setup}, 32'd1);
        chk("o_remain", {16'd0, pio_remain}, 32'd4);
        send_beat(32'h4600_0000, U_SOP);
        send_beat(32'h1111_1111, U_MID);
        #1 chk("o_done1",  {31'd0, pio_done}, 32'd1);
        chk("o_noerr1", {31'd0, fis_err}, 32'd0);
        send_beat(32'h2222_2222, U_EOP);
        end_burst();
        chk("o_done2",  {31'd0, pio_done}, 32'd1);
        chk("o_ferr2",  {31'd0, fis_err}, 32'd1);
        chk("o_remain0", {16'd0, pio_remain}, 32'd0);

        // err beat in DATA leaves the count alone
        send_beat(32'h5F20_5000, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0800_0000, U_EOP);
        end_burst();
        send_beat(32'h4600_0000, U_SOP);
        send_beat(32'h3333_3333, U_ERR);
        #1 chk("de_ferr",   {31'd0, fis_err}, 32'd1);
        chk("de_remain", {16'd0, pio_remain}, 32'd8);
        send_beat(32'h4444_4444, U_EOP);
        end_burst();
        chk("de_remain4", {16'd0, pio_remain}, 32'd4);
        chk("de_no_done", {31'd0, pio_done}, 32'd0);

        // drop beat inside a PIO Setup: no descriptor update
        send_beat(32'h5F60_9902, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0000_0000, U_DROP);
        #1 chk("pd_ferr", {31'd0, fis_err}, 32'd1);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0700_0000, U_EOP);
        end_burst();
        chk("pd_no_setup", {31'd0, pio_setup}, 32'd0);
        chk("pd_status",   {24'd0, pio_status}, 32'h50);
        chk("pd_xfer",     {16'd0, pio_xfer_cnt}, 32'h0008);

        // Reset in the middle of a PIO Setup
        send_beat(32'h5F60_9902, U_SOP);
        send_beat(32'h0000_0000, U_MID);
        @(negedge clk);
        tvalid = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mr_valid",  {31'd0, pio_valid}, 32'd0);
        chk("mr_status", {24'd0, pio_status}, 32'h00);
        chk("mr_xfer",   {16'd0, pio_xfer_cnt}, 32'h0000);
        chk("mr_remain", {16'd0, pio_remain}, 32'h0000);
        chk("mr_dir",    {31'd0, pio_dir}, 32'd0);
        chk("mr_tready", {31'd0, tready}, 32'd1);
        send_beat(32'h0000_0000, U_MID);
        send_beat(32'h0500_0000, U_EOP);
        end_burst();
        chk("mr_discard_setup", {31'd0, pio_setup}, 32'd0);
        chk("mr_discard_ferr",  {31'd0, fis_err}, 32'd0);
        chk("mr_discard_xfer",  {16'd0, pio_xfer_cnt}, 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
